// File: rtl/mux_4to1_arb.sv
// Round-robin arbiter driving the select/enable of a downstream 4:1 mux.
// Grants are bounded to MAXHOLD cycles, and every release is followed by one idle cycle.
module mux_4to1_arb #(
  parameter int unsigned MAXHOLD = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic       en,
  output logic [3:0] gnt,
  output logic       timeout
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 2;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAXHOLD - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]       state, state_d;
  logic [IDX_W-1:0] ptr, ptr_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [IDX_W-1:0] sel_d;
  logic             en_d;
  logic [N_REQ-1:0] gnt_d;
  logic             timeout_d;

  logic [IDX_W-1:0] winner_c;
  logic             found_c;
  logic             expire_c;
  logic             release_c;

  // First requester at or after ptr, wrapping mod 4
  always_comb begin
    winner_c = ptr;
    found_c  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found_c && req[ptr + IDX_W'(k)]) begin
        winner_c = ptr + IDX_W'(k);
        found_c  = 1'b1;
      end
    end
  end

  assign expire_c  = (cnt == HOLD_LAST);
  assign release_c = !req[sel] || done || expire_c;

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      sel     <= '0;
      en      <= 1'b0;
      gnt     <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      cnt     <= cnt_d;
      sel     <= sel_d;
      en      <= en_d;
      gnt     <= gnt_d;
      timeout <= timeout_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    cnt_d     = cnt;
    sel_d     = sel;
    en_d      = en;
    gnt_d     = gnt;
    timeout_d = 1'b0;
    case (state)
      IDLE: begin
        en_d  = 1'b0;
        gnt_d = '0;
        cnt_d = '0;
        if (found_c) begin
          state_d = GRANT;
          sel_d   = winner_c;
          en_d    = 1'b1;
          gnt_d   = N_REQ'(1) << winner_c;
        end
      end
      GRANT: begin
        if (release_c) begin
          state_d = IDLE;
          en_d    = 1'b0;
          gnt_d   = '0;
          cnt_d   = '0;
          ptr_d   = sel + IDX_W'(1);
          // Timeout only when expiry alone ended the grant
          timeout_d = expire_c && req[sel] && !done;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

endmodule
